// File: rtl/usb_hub_pkg.sv
// -----------------------------------------------------------------------------
// usb_hub_pkg
// Shared definitions for the hub's full-speed receive front end:
//   - line state encodings as seen on the synchronized {D+,D-} pair
//   - receive FSM state enum
//   - bit-stuffing and EOP length limits
// No ports (package).
// -----------------------------------------------------------------------------
package usb_hub_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } rx_state_t;

    // Consecutive decoded ones after which a stuffed zero must follow.
    localparam int MAX_ONES     = 6;
    // SE0 longer than this many bit times is a bus reset, not an EOP.
    localparam int EOP_MAX_BITS = 3;

endpackage

// File: rtl/usb_rx_dpll.sv
// -----------------------------------------------------------------------------
// usb_rx_dpll
// Synchronizes the raw D+/D- receiver outputs, optionally filters one-sample
// SE0 glitches, and recovers bit timing with a phase counter that re-aligns
// on every J<->K transition. Emits a one-cycle strobe at mid-bit together
// with the (filtered) line state sampled at that point.
//
// Optional feature macro: USB_RX_SE0_FILTER_EN
//   defined   : SE0 must be seen on two consecutive samples before the strobe
//               logic honors it (line_state still shows the raw value).
//   undefined : every SE0 sample is passed through.
//
// Ports:
//   hi_clock    in   oversampling clock
//   reset_n     in   active-low reset (asynchronous assert)
//   rx_plus     in   raw D+ (asynchronous)
//   rx_minus    in   raw D- (asynchronous)
//   line_state  out  synchronized {D+,D-}
//   bit_strobe  out  one-cycle mid-bit strobe
//   strobe_ls   out  filtered line state, meaningful when bit_strobe is high
// -----------------------------------------------------------------------------
module usb_rx_dpll
    import usb_hub_pkg::*;
#(
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       hi_clock,
    input  logic       reset_n,
    input  logic       rx_plus,
    input  logic       rx_minus,
    output logic [1:0] line_state,
    output logic       bit_strobe,
    output logic [1:0] strobe_ls
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MAX   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STROBE_AT = CW'(OVERSAMPLE / 2 - 1);

    logic [SYNC_STAGES-1:0] plus_sync_reg;
    logic [SYNC_STAGES-1:0] minus_sync_reg;
    logic [1:0]             raw_ls;
    logic [1:0]             eff_ls;
    logic [1:0]             last_diff_reg;
    logic [CW-1:0]          phase_reg;
    logic                   is_diff;
    logic                   level_change;

    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            plus_sync_reg  <= '0;
            minus_sync_reg <= '0;
        end else begin
            plus_sync_reg  <= {plus_sync_reg[SYNC_STAGES-2:0], rx_plus};
            minus_sync_reg <= {minus_sync_reg[SYNC_STAGES-2:0], rx_minus};
        end
    end

    assign raw_ls     = {plus_sync_reg[SYNC_STAGES-1], minus_sync_reg[SYNC_STAGES-1]};
    assign line_state = raw_ls;

`ifdef USB_RX_SE0_FILTER_EN
    logic [1:0] prev_raw_reg;
    logic [1:0] eff_prev_reg;

    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_raw_reg <= LS_SE0;
            eff_prev_reg <= LS_SE0;
        end else begin
            prev_raw_reg <= raw_ls;
            eff_prev_reg <= eff_ls;
        end
    end

    // First SE0 sample is masked by holding the previous filtered state.
    assign eff_ls = (raw_ls == LS_SE0 && prev_raw_reg != LS_SE0) ? eff_prev_reg : raw_ls;
`else
    assign eff_ls = raw_ls;
`endif

    assign is_diff      = (eff_ls == LS_J) || (eff_ls == LS_K);
    // SE0/SE1 do not re-align the phase; only differential transitions do.
    assign level_change = is_diff && (eff_ls != last_diff_reg);

    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg     <= '0;
            last_diff_reg <= LS_J;
        end else begin
            if (is_diff) begin
                last_diff_reg <= eff_ls;
            end
            if (level_change || phase_reg == CNT_MAX) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    assign bit_strobe = (phase_reg == STROBE_AT);
    assign strobe_ls  = eff_ls;

endmodule

// File: rtl/usb_rx_phy.sv
// -----------------------------------------------------------------------------
// usb_rx_phy
// Full-speed USB receive front end: DPLL bit recovery (usb_rx_dpll), NRZI
// decode, SYNC detection, bit unstuffing, byte assembly and EOP detection.
// The optional SE0 glitch filter inside the DPLL is enabled by defining
// USB_RX_SE0_FILTER_EN.
//
// Ports:
//   hi_clock    in   OVERSAMPLE x bit-rate clock
//   reset_n     in   active-low reset, asynchronous assert / synchronous release
//   rx_plus     in   raw D+ receiver output
//   rx_minus    in   raw D- receiver output
//   rx_enable   in   receiver enable (low while the hub transmits)
//   line_state  out  synchronized {D+,D-}
//   rx_active   out  high from end of SYNC until EOP/error
//   rx_data     out  received byte (valid with rx_valid)
//   rx_valid    out  one-cycle strobe per byte
//   rx_error    out  one-cycle strobe on stuff violation, SE1 or misaligned EOP
// -----------------------------------------------------------------------------
module usb_rx_phy
    import usb_hub_pkg::*;
#(
    parameter int OVERSAMPLE   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic       hi_clock,
    input  logic       reset_n,
    input  logic       rx_plus,
    input  logic       rx_minus,
    input  logic       rx_enable,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int TW = $clog2(SYNC_TIMEOUT);
    localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TIMEOUT - 1);

    logic [1:0]    rst_sync_reg;
    logic          rst_n_int;
    logic          bit_strobe;
    logic [1:0]    strobe_ls;
    logic          is_k;
    logic          is_diff;
    logic          nrzi_bit;

    rx_state_t     state_reg;
    logic          prev_k_reg;
    logic [TW-1:0] sync_cnt_reg;
    logic [2:0]    ones_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [1:0]    se0_cnt_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_active_reg;
    logic          rx_valid_reg;
    logic          rx_error_reg;

    // Assertion reaches every flop at once; release is re-timed to hi_clock.
    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_reg[1];

    usb_rx_dpll #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dpll (
        .hi_clock   (hi_clock),
        .reset_n    (rst_n_int),
        .rx_plus    (rx_plus),
        .rx_minus   (rx_minus),
        .line_state (line_state),
        .bit_strobe (bit_strobe),
        .strobe_ls  (strobe_ls)
    );

    assign is_k     = (strobe_ls == LS_K);
    assign is_diff  = (strobe_ls == LS_K) || (strobe_ls == LS_J);
    assign nrzi_bit = (is_k == prev_k_reg);

    always_ff @(posedge hi_clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg     <= ST_IDLE;
            prev_k_reg    <= 1'b0;
            sync_cnt_reg  <= '0;
            ones_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            se0_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_active_reg <= 1'b0;
            rx_valid_reg  <= 1'b0;
            rx_error_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            rx_error_reg <= 1'b0;
            if (!rx_enable) begin
                state_reg     <= ST_IDLE;
                rx_active_reg <= 1'b0;
                bit_cnt_reg   <= '0;
                ones_cnt_reg  <= '0;
            end else if (bit_strobe) begin
                if (is_diff) begin
                    prev_k_reg <= is_k;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (is_k) begin
                            state_reg    <= ST_SYNC;
                            sync_cnt_reg <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (!is_diff) begin
                            state_reg <= ST_IDLE;
                        end else if (is_k && prev_k_reg) begin
                            state_reg     <= ST_DATA;
                            rx_active_reg <= 1'b1;
                            bit_cnt_reg   <= '0;
                            ones_cnt_reg  <= '0;
                        end else if (sync_cnt_reg == SYNC_LAST) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            sync_cnt_reg <= sync_cnt_reg + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (strobe_ls == LS_SE0) begin
                            state_reg    <= ST_EOP;
                            se0_cnt_reg  <= 2'd1;
                            rx_error_reg <= (bit_cnt_reg != 3'd0);
                        end else if (strobe_ls == LS_SE1) begin
                            state_reg     <= ST_ERR;
                            rx_error_reg  <= 1'b1;
                            rx_active_reg <= 1'b0;
                        end else if (ones_cnt_reg == 3'(MAX_ONES)) begin
                            // Stuff position: a zero is discarded, a one is illegal.
                            if (nrzi_bit) begin
                                state_reg     <= ST_ERR;
                                rx_error_reg  <= 1'b1;
                                rx_active_reg <= 1'b0;
                            end else begin
                                ones_cnt_reg <= '0;
                            end
                        end else begin
                            shift_reg    <= {nrzi_bit, shift_reg[7:1]};
                            ones_cnt_reg <= nrzi_bit ? ones_cnt_reg + 1'b1 : 3'd0;
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data_reg  <= {nrzi_bit, shift_reg[7:1]};
                                rx_valid_reg <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (strobe_ls == LS_SE0) begin
                            if (se0_cnt_reg == 2'(EOP_MAX_BITS)) begin
                                state_reg     <= ST_IDLE;
                                rx_active_reg <= 1'b0;
                            end else begin
                                se0_cnt_reg <= se0_cnt_reg + 1'b1;
                            end
                        end else begin
                            state_reg     <= ST_IDLE;
                            rx_active_reg <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                        rx_active_reg <= 1'b0;
                        if (strobe_ls == LS_J) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        rx_active_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_active = rx_active_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_error  = rx_error_reg;

endmodule
